// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Shares one 64-bit physical-memory port between the instruction-cache
//   fill port (I) and the data-cache fill/writeback port (D). A 256-bit line
//   is moved as a burst of four 64-bit beats. Only one memory transaction is
//   outstanding at a time.
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   i_read, i_address    : I line-fill request and line address ([4:0] ignored)
//   i_resp, i_rdata      : I completion pulse and filled line
//   d_read, d_write      : D line-fill / writeback requests
//   d_address, d_wdata   : D line address ([4:0] ignored) and writeback line
//   d_resp, d_rdata      : D completion pulse and filled line
//   pmem_read/pmem_write : memory read / write burst in progress
//   pmem_address         : line-aligned burst address
//   pmem_wdata           : current write beat
//   pmem_rdata/pmem_resp : current read beat / beat handshake
//   dbg_state, dbg_beat  : FSM state (0 IDLE, 1 BURST, 2 RESP) and beat counter
//
// Handshake: in BURST the command (pmem_read or pmem_write) and pmem_address
// are held steady; a beat moves in every cycle where pmem_resp=1, and memory
// may stall any number of cycles by holding pmem_resp=0. pmem_resp outside
// BURST is ignored. Requesters hold their request until the cycle of their
// *_resp pulse and drop it at the edge that ends that cycle.
module cache_mem_arbiter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_read,
    input  logic [31:0]  i_address,
    output logic         i_resp,
    output logic [255:0] i_rdata,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [31:0]  d_address,
    input  logic [255:0] d_wdata,
    output logic         d_resp,
    output logic [255:0] d_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [63:0]  pmem_wdata,
    input  logic [63:0]  pmem_rdata,
    input  logic         pmem_resp,
    output logic [1:0]   dbg_state,
    output logic [1:0]   dbg_beat
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [1:0]     beat;
    logic           last_grant_d;   // 0: I was granted last, 1: D was
    logic           owner_d;        // owner of the current transaction
    logic           op_write;
    logic [26:0]    line_addr;
    logic [255:0]   line_buf;

    logic           i_pend;
    logic           d_pend;
    logic           grant_any;
    logic           grant_d;
    logic [7:0]     beat_lsb;

    // Round-robin: on a tie, the port that was not granted last wins.
    // A D port asking for both read and write is granted as a write first;
    // its read stays asserted and is arbitrated again in a later IDLE.
    always_comb begin
        i_pend    = i_read;
        d_pend    = d_read | d_write;
        grant_any = i_pend | d_pend;
        grant_d   = d_pend & (~i_pend | ~last_grant_d);
        beat_lsb  = {beat, 6'b0};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any) state_next = BURST;
            BURST:   if (pmem_resp && beat == 2'd3) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat         <= 2'd0;
            last_grant_d <= 1'b0;
            owner_d      <= 1'b0;
            op_write     <= 1'b0;
            line_addr    <= 27'd0;
            line_buf     <= 256'd0;
        end else begin
            if (state == IDLE && grant_any) begin
                owner_d      <= grant_d;
                last_grant_d <= grant_d;
                op_write     <= grant_d & d_write;
                line_addr    <= grant_d ? d_address[31:5] : i_address[31:5];
                beat         <= 2'd0;
                if (grant_d && d_write) begin
                    line_buf <= d_wdata;
                end
            end else if (state == BURST && pmem_resp) begin
                if (!op_write) begin
                    line_buf[beat_lsb +: 64] <= pmem_rdata;
                end
                // The last beat wraps the counter back to 0 as the burst ends.
                beat <= beat + 2'd1;
            end
        end
    end

    // All outputs decode registered state only.
    always_comb begin
        pmem_read    = (state == BURST) & ~op_write;
        pmem_write   = (state == BURST) & op_write;
        pmem_address = {line_addr, 5'b0};
        pmem_wdata   = line_buf[beat_lsb +: 64];
        i_resp       = (state == RESP) & ~owner_d;
        d_resp       = (state == RESP) & owner_d;
        i_rdata      = line_buf;
        d_rdata      = line_buf;
        dbg_state    = state;
        dbg_beat     = beat;
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  logic         clk;
  logic         rst_n;
  logic         i_read;
  logic [31:0]  i_address;
  logic         i_resp;
  logic [255:0] i_rdata;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_address;
  logic [255:0] d_wdata;
  logic         d_resp;
  logic [255:0] d_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [63:0]  pmem_wdata;
  logic [63:0]  pmem_rdata;
  logic         pmem_resp;
  logic [1:0]   dbg_state;
  logic [1:0]   dbg_beat;

  cache_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .dbg_state(dbg_state), .dbg_beat(dbg_beat)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;

  // {is_d, check_data, line}
  localparam int W = 258;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] wline;
  } burst_t;
  burst_t burst_q[$];

  int  mem_waits = 0;
  logic stray_resp = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory content model: the 0x1040 line holds the hand-written pattern,
  // every other line holds its address tagged with the beat number.
  function automatic logic [63:0] beat_data(input logic [31:0] a, input int b);
    logic [7:0] k;
    if (a == 32'h0000_1040) begin
      k = 8'h11 * 8'(b + 1);
      return {8{k}};
    end
    return {a, 32'hC0DE_0000 | 32'(b)};
  endfunction

  function automatic logic [255:0] exp_line(input logic [31:0] a);
    return {beat_data(a, 3), beat_data(a, 2), beat_data(a, 1), beat_data(a, 0)};
  endfunction

  // ---------------- memory responder ----------------
  initial begin : mem_model
    burst_t cur;
    bit     in_burst;
    int     beat_idx;
    int     wait_cnt;
    pmem_resp  = 1'b0;
    pmem_rdata = 64'd0;
    in_burst   = 0;
    beat_idx   = 0;
    wait_cnt   = 0;
    cur.wr = 1'b0; cur.addr = 32'd0; cur.wline = 256'd0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (rst_n && (pmem_read || pmem_write)) begin
        if (!in_burst) begin
          in_burst = 1;
          beat_idx = 0;
          wait_cnt = 0;
          if (burst_q.size() == 0) begin
            chk("burst_unexpected", 256'(pmem_address), 256'hFFFF_FFFF_FFFF);
          end else begin
            cur = burst_q.pop_front();
            chk("burst_op_write", 256'(pmem_write), 256'(cur.wr));
            chk("burst_op_read", 256'(pmem_read), 256'(!cur.wr));
            chk("burst_address", 256'(pmem_address), 256'(cur.addr));
          end
        end
        if (cur.wr) chk("pmem_wdata", 256'(pmem_wdata), 256'(cur.wline[64*beat_idx +: 64]));
        if (wait_cnt < mem_waits) begin
          wait_cnt++;
        end else begin
          wait_cnt   = 0;
          pmem_resp  = 1'b1;
          pmem_rdata = beat_data(cur.addr, beat_idx);
          beat_idx++;
        end
      end else begin
        in_burst  = 0;
        beat_idx  = 0;
        wait_cnt  = 0;
        pmem_resp = stray_resp;
      end
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && (i_resp || d_resp)) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 256'({i_resp, d_resp}), 256'd0);
      end else begin
        e = exp_q.pop_front();
        chk("resp_port", 256'({i_resp, d_resp}), e[W-1] ? 256'd1 : 256'd2);
        if (e[W-2]) chk("resp_data", e[W-1] ? d_rdata : i_rdata, e[255:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_burst(input logic wr, input logic [31:0] a, input logic [255:0] wl);
    burst_t b;
    b.wr = wr; b.addr = {a[31:5], 5'b0}; b.wline = wl;
    burst_q.push_back(b);
  endtask

  task automatic push_resp(input logic is_d, input logic chk_data, input logic [255:0] line);
    exp_q.push_back({is_d, chk_data, line});
  endtask

  // Waits (from a negedge) for the requested resp; counts cycles and command cycles.
  task automatic wait_resp(input logic want_d, output int cyc, output int cmd_cnt);
    cyc = 0;
    cmd_cnt = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      cyc++;
      if (pmem_read || pmem_write) cmd_cnt++;
      if (want_d ? d_resp : i_resp) return;
    end
    chk("resp_timeout", 256'(want_d), 256'(~want_d));
    cyc = -1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_cmd_resp"}, 256'({pmem_read, pmem_write, i_resp, d_resp}), 256'd0);
    chk({tag, "_state"}, 256'(dbg_state), 256'd0);
    chk({tag, "_beat"}, 256'(dbg_beat), 256'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int cyc;
    int cmd;
    int nresp;
    logic [255:0] wl;

    rst_n = 1'b0;
    i_read = 1'b0; i_address = 32'd0;
    d_read = 1'b0; d_write = 1'b0; d_address = 32'd0; d_wdata = 256'd0;

    // Reset values
    #23;
    check_idle_outputs("reset");
    chk("reset_addr", 256'(pmem_address), 256'd0);
    chk("reset_wdata", 256'(pmem_wdata), 256'd0);
    chk("reset_i_rdata", i_rdata, 256'd0);
    chk("reset_d_rdata", d_rdata, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stray pmem_resp in IDLE
    stray_resp = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_idle_outputs("stray");
    end
    stray_resp = 1'b0;
    @(negedge clk);

    // Tie after reset: D, I, D, I with both held
    mem_waits = 0;
    push_burst(1'b0, 32'h2000_001F, 256'd0); push_resp(1'b1, 1'b1, exp_line(32'h2000_0000));
    push_burst(1'b0, 32'h0000_3004, 256'd0); push_resp(1'b0, 1'b1, exp_line(32'h0000_3000));
    push_burst(1'b0, 32'h2000_001F, 256'd0); push_resp(1'b1, 1'b1, exp_line(32'h2000_0000));
    push_burst(1'b0, 32'h0000_3004, 256'd0); push_resp(1'b0, 1'b1, exp_line(32'h0000_3000));
    d_address = 32'h2000_001F; d_read = 1'b1;
    i_address = 32'h0000_3004; i_read = 1'b1;
    nresp = 0;
    for (int n = 0; n < 200 && nresp < 4; n++) begin
      @(negedge clk);
      if (i_resp || d_resp) nresp++;
    end
    chk("tie_resp_count", 256'(nresp), 256'd4);
    i_read = 1'b0; d_read = 1'b0;
    @(negedge clk);

    // I read of 0x105C, zero wait states: 5-cycle latency
    push_burst(1'b0, 32'h0000_105C, 256'd0);
    push_resp(1'b0, 1'b1, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    i_address = 32'h0000_105C; i_read = 1'b1;
    wait_resp(1'b0, cyc, cmd);
    i_read = 1'b0;
    chk("iread_latency", 256'(cyc), 256'd5);
    chk("iread_cmd_cycles", 256'(cmd), 256'd4);
    chk("iread_no_dresp", 256'(d_resp), 256'd0);
    @(negedge clk);

    // D write, two wait cycles per beat: resp 13 cycles after request
    mem_waits = 2;
    wl = {4{64'hDDDD_CCCC_BBBB_AAAA}};
    push_burst(1'b1, 32'h0000_8000, wl); push_resp(1'b1, 1'b0, 256'd0);
    d_address = 32'h0000_8000; d_wdata = wl; d_write = 1'b1;
    wait_resp(1'b1, cyc, cmd);
    d_write = 1'b0;
    chk("dwrite_latency", 256'(cyc), 256'd13);
    chk("dwrite_cmd_cycles", 256'(cmd), 256'd12);
    chk("dwrite_no_iresp", 256'(i_resp), 256'd0);
    @(negedge clk);

    // D read + write together: write first, then read, two resps
    mem_waits = 1;
    wl = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
          64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
    push_burst(1'b1, 32'h4000_0040, wl);      push_resp(1'b1, 1'b0, 256'd0);
    push_burst(1'b0, 32'h4000_0040, 256'd0);  push_resp(1'b1, 1'b1, exp_line(32'h4000_0040));
    d_address = 32'h4000_0040; d_wdata = wl; d_read = 1'b1; d_write = 1'b1;
    wait_resp(1'b1, cyc, cmd);
    d_write = 1'b0;
    chk("drw_write_latency", 256'(cyc), 256'd9);
    wait_resp(1'b1, cyc, cmd);
    d_read = 1'b0;
    chk("drw_read_latency", 256'(cyc), 256'd10);
    @(negedge clk);

    // Reset during beat 2 of a read
    mem_waits = 1;
    push_burst(1'b0, 32'h0000_5000, 256'd0); push_resp(1'b0, 1'b1, exp_line(32'h0000_5000));
    i_address = 32'h0000_5000; i_read = 1'b1;
    cyc = 0;
    while (dbg_beat != 2'd2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_reach_beat2", 256'(dbg_beat), 256'd2);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    chk("rst_mid_addr", 256'(pmem_address), 256'd0);
    chk("rst_mid_rdata", i_rdata, 256'd0);
    exp_q.delete();
    i_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_after");

    // Normal request after reset
    mem_waits = 0;
    push_burst(1'b0, 32'h0000_6010, 256'd0); push_resp(1'b1, 1'b1, exp_line(32'h0000_6000));
    d_address = 32'h0000_6010; d_read = 1'b1;
    wait_resp(1'b1, cyc, cmd);
    d_read = 1'b0;
    chk("post_rst_latency", 256'(cyc), 256'd5);
    repeat (3) @(negedge clk);

    chk("exp_q_drained", 256'(exp_q.size()), 256'd0);
    chk("burst_q_drained", 256'(burst_q.size()), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
